// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 8-input mux scan controller.
package mux_scan_pkg;

    // Width of the scan index that walks mux inputs a..h.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    // Index to mux select lines, returned as {sel_m, sel_j, sel_i}.
    // The downstream mux has inverted select sense, so each line is the
    // complement of its index bit. Index bit 0 is wired to sel_j and
    // bit 1 to sel_i.
    function automatic logic [2:0] idx_to_sel(input logic [IDX_W-1:0] k);
        return {~k[2], ~k[0], ~k[1]};
    endfunction

endpackage

// File: rtl/mux8_sel_encode.sv
// Combinational scan-index to mux-select encoder.
module mux8_sel_encode
    import mux_scan_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic             sel_i,
    output logic             sel_j,
    output logic             sel_m
);

    logic [2:0] sel_mji;

    // Decode the index through the shared encoding function.
    always_comb begin
        sel_mji = idx_to_sel(idx);
    end

    assign sel_m = sel_mji[2];
    assign sel_j = sel_mji[1];
    assign sel_i = sel_mji[0];

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scans all eight inputs of a downstream 8-to-1 mux, one at a time,
// assembles the sampled mux output into a byte and holds it until the
// consumer acknowledges it.
//
// Handshake: valid rises when data_out holds a complete word and stays
// high (data_out frozen) until a clock edge that sees ack=1 while valid=1;
// valid falls on the following cycle. ack without valid is ignored.
module mux8_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_y,
    input  logic       ack,
    output logic       sel_i,
    output logic       sel_j,
    output logic       sel_m,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       valid
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    // With no settle time every index lives only in SAMPLE.
    localparam logic       NO_SETTLE = (SETTLE_CYCLES == 0);

    scan_state_t      state;
    scan_state_t      state_nx;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] k_nx;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nx;
    logic [7:0]       data_nx;
    logic             sel_i_nx;
    logic             sel_j_nx;
    logic             sel_m_nx;

    // Next-state, index, settle counter and data word.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        cnt_nx   = cnt;
        data_nx  = data_out;
        case (state)
            ST_IDLE: begin
                k_nx = '0;
                if (start) begin
                    cnt_nx   = SETTLE_LD;
                    state_nx = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // SETTLE lasts SETTLE_CYCLES cycles; leave as the count hits 0.
                if (cnt <= 4'd1) begin
                    cnt_nx   = 4'd0;
                    state_nx = ST_SAMPLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                data_nx[k] = mux_y;
                if (k == 3'd7) begin
                    k_nx     = '0;
                    cnt_nx   = 4'd0;
                    state_nx = ST_DONE;
                end else begin
                    k_nx     = k + 3'd1;
                    cnt_nx   = SETTLE_LD;
                    state_nx = NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                k_nx = '0;
                // start alongside ack is deliberately not a restart.
                if (ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                k_nx     = '0;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Selects are computed from the next index so the registered lines
    // present index k for every cycle the FSM holds index k.
    mux8_sel_encode u_sel_encode (
        .idx   (k_nx),
        .sel_i (sel_i_nx),
        .sel_j (sel_j_nx),
        .sel_m (sel_m_nx)
    );

    // State, index, counter, data and registered select lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            k        <= '0;
            cnt      <= 4'd0;
            data_out <= 8'h00;
            sel_i    <= 1'b1;
            sel_j    <= 1'b1;
            sel_m    <= 1'b1;
        end else begin
            state    <= state_nx;
            k        <= k_nx;
            cnt      <= cnt_nx;
            data_out <= data_nx;
            sel_i    <= sel_i_nx;
            sel_j    <= sel_j_nx;
            sel_m    <= sel_m_nx;
        end
    end

    assign busy  = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign valid = (state == ST_DONE);

endmodule

// File: doc/mux8_scan_ctrl.md
MUX8_SCAN_CTRL -- requirements
Module: mux8_scan_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, range 0..15; extra cycles each select value is held before mux_y is sampled.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one scan of all 8 mux inputs; sampled only in IDLE.
REQ-006 mux_y  input  1  output Y of the downstream 8-to-1 tri-state mux.
REQ-007 sel_i  output  1  drives mux select i.
REQ-008 sel_j  output  1  drives mux select j.
REQ-009 sel_m  output  1  drives mux select m.
REQ-010 busy  output  1  high while a scan is in progress (SETTLE/SAMPLE states).
REQ-011 data_out  output  8  assembled word; bit k holds mux input k (a=0 ... h=7).
REQ-012 valid  output  1  data_out holds a complete word; held until acknowledged.
REQ-013 ack  input  1  consumer accepts data_out; sampled only while valid=1.

Function
REQ-014 Scan index k (3 bits) SHALL map to selects: sel_j = ~k[0], sel_i = ~k[1], sel_m = ~k[2], so that k selects mux input a..h in order.
REQ-015 Select sequence as {sel_m,sel_j,sel_i} for k=0..7 SHALL be 111,101,110,100,011,001,010,000.
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: selects drive k=0, busy=0, valid=0; start=1 at a clock edge -> SETTLE with k=0, settle counter loaded with SETTLE_CYCLES.
REQ-018 SETTLE: counter decrements each cycle; at 0 -> SAMPLE (SETTLE_CYCLES=0 goes directly to SAMPLE on the next cycle).
REQ-019 SAMPLE: mux_y registered into data_out[k] at the state's exiting edge; if k<7 -> SETTLE with k+1 and counter reloaded, else -> DONE.
REQ-020 Each k SHALL be driven for exactly SETTLE_CYCLES+1 cycles; start-edge to valid latency SHALL be 8*(SETTLE_CYCLES+1) cycles.
REQ-021 data_out bits not yet sampled in the current scan SHALL keep prior values; data_out is stable throughout DONE.
REQ-022 DONE: valid=1, busy=0, selects drive k=0; ack=1 -> IDLE (valid falls next cycle).
REQ-023 start asserted in SETTLE, SAMPLE or DONE SHALL be ignored, including start and ack asserted together in DONE.
REQ-024 ack outside DONE SHALL be ignored.
REQ-025 Selects SHALL be registered outputs (glitch-free) changing only on clk edges.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, k=0, counter=0, data_out=8'h00, valid=0, busy=0, {sel_m,sel_j,sel_i}=111, asynchronously and regardless of state.
REQ-027 Reset mid-scan SHALL discard the partial word; first scan after release requires a fresh start.

Structure
REQ-028 Package mux_scan_pkg SHALL hold the state enum, IDX_W=3 constant and the index-to-select encoding function.
REQ-029 One sub-module, mux8_sel_encode (3-bit index in, sel_i/sel_j/sel_m out, combinational), SHALL implement REQ-014; its outputs are registered in mux8_scan_ctrl.

Verification
REQ-030 Reset: assert rst mid-cycle -> all outputs at REQ-026 values without a clock edge.
REQ-031 DUT drives a triState_mux8to1 with inputs {h..a}=8'b1010_0110, SETTLE_CYCLES=1, pulse start -> valid rises 16 cycles later, data_out=8'hA6, selects follow REQ-015 each held 2 cycles.
REQ-032 SETTLE_CYCLES=0, inputs 8'h5C -> valid after 8 cycles, data_out=8'h5C.
REQ-033 Hold ack=0 for 10 cycles after valid -> valid and data_out steady; pulse start during scan and during DONE -> no restart; ack=1 -> IDLE next cycle.
REQ-034 rst at cycle 5 of a scan -> IDLE, data_out=8'h00; new start with inputs 8'hFF -> data_out=8'hFF after 16 cycles.
REQ-035 Back-to-back: ack and start in consecutive cycles with inputs 8'h3A then 8'hC5 -> two valid words 8'h3A, 8'hC5.
